// File: rtl/mvm_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mvm_uart_ctrl
// Description : Sequencer between a UART receiver, the matrix/vector memories,
//               a matrix-vector compute engine and a UART transmitter. Loads
//               R*C matrix words and C vector words, starts the engine, then
//               streams the R result words back out.
// Revision    : 1.0 - initial release
// ============================================================================
module mvm_uart_ctrl #(
  parameter int R    = 8,
  parameter int C    = 8,
  parameter int W_IN = 8,
  parameter int W_Y  = 32,
  localparam int KAW = (R * C > 1) ? $clog2(R * C) : 1,
  localparam int XAW = (C > 1) ? $clog2(C) : 1,
  localparam int YAW = (R > 1) ? $clog2(R) : 1
) (
  input  logic            clk,
  input  logic            rstn,
  // receiver side
  input  logic            rx_valid,
  input  logic [W_IN-1:0] rx_data,
  // matrix memory write port
  output logic            k_we,
  output logic [KAW-1:0]  k_addr,
  output logic [W_IN-1:0] k_wdata,
  // vector memory write port
  output logic            x_we,
  output logic [XAW-1:0]  x_addr,
  output logic [W_IN-1:0] x_wdata,
  // compute engine handshake
  output logic            mvm_start,
  input  logic            mvm_done,
  // result memory read port (1-cycle read latency)
  output logic [YAW-1:0]  y_addr,
  input  logic [W_Y-1:0]  y_rdata,
  // transmitter side
  output logic            tx_valid,
  output logic [W_Y-1:0]  tx_data,
  input  logic            tx_ready,
  // status
  output logic            busy,
  output logic            rx_drop
);

  // Terminal counter values, all at counter width so compares stay matched.
  localparam logic [KAW-1:0] K_LAST = KAW'(R * C - 1);
  localparam logic [KAW-1:0] X_LAST = KAW'(C - 1);
  localparam logic [KAW-1:0] Y_LAST = KAW'(R - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_K    = 3'd1,
    LOAD_X    = 3'd2,
    START     = 3'd3,
    WAIT_DONE = 3'd4,
    SEND_RD   = 3'd5,
    SEND_TX   = 3'd6
  } state_t;

  state_t            state_q;
  logic [KAW-1:0]    cnt_q;
  logic              k_we_q;
  logic [KAW-1:0]    k_addr_q;
  logic [W_IN-1:0]   k_wdata_q;
  logic              x_we_q;
  logic [XAW-1:0]    x_addr_q;
  logic [W_IN-1:0]   x_wdata_q;
  logic              mvm_start_q;
  logic [YAW-1:0]    y_addr_q;
  logic              tx_valid_q;
  logic [W_Y-1:0]    tx_data_q;
  logic              busy_q;
  logic              rx_drop_q;

  // Single sequencer: state, shared word counter and every registered output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      k_we_q      <= 1'b0;
      k_addr_q    <= '0;
      k_wdata_q   <= '0;
      x_we_q      <= 1'b0;
      x_addr_q    <= '0;
      x_wdata_q   <= '0;
      mvm_start_q <= 1'b0;
      y_addr_q    <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      rx_drop_q   <= 1'b0;
    end else begin
      // Write and start strobes are single-cycle unless re-armed below.
      k_we_q      <= 1'b0;
      x_we_q      <= 1'b0;
      mvm_start_q <= 1'b0;

      case (state_q)
        // The first word seen in IDLE is matrix element 0; IDLE and LOAD_K
        // share the load path so no word is lost on the way in.
        IDLE, LOAD_K: begin
          if (rx_valid) begin
            k_we_q    <= 1'b1;
            k_addr_q  <= cnt_q;
            k_wdata_q <= rx_data;
            busy_q    <= 1'b1;
            if (cnt_q == K_LAST) begin
              cnt_q   <= '0;
              state_q <= LOAD_X;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= LOAD_K;
            end
          end
        end

        LOAD_X: begin
          if (rx_valid) begin
            x_we_q    <= 1'b1;
            x_addr_q  <= cnt_q[XAW-1:0];
            x_wdata_q <= rx_data;
            if (cnt_q == X_LAST) begin
              cnt_q   <= '0;
              state_q <= START;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
            end
          end
        end

        // The start pulse is registered here, so it appears in the cycle
        // after the final vector write has landed.
        START: begin
          mvm_start_q <= 1'b1;
          state_q     <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (mvm_done) begin
            cnt_q    <= '0;
            y_addr_q <= '0;
            state_q  <= SEND_RD;
          end
        end

        // y_addr is already presented; the memory samples it at the end of
        // this cycle and returns data during the first SEND_TX cycle.
        SEND_RD: begin
          state_q <= SEND_TX;
        end

        // First cycle captures the read data; afterwards hold tx_valid and
        // tx_data until the transmitter takes the word.
        SEND_TX: begin
          if (!tx_valid_q) begin
            tx_data_q  <= y_rdata;
            tx_valid_q <= 1'b1;
          end else if (tx_ready) begin
            tx_valid_q <= 1'b0;
            if (cnt_q == Y_LAST) begin
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              cnt_q    <= cnt_q + 1'b1;
              y_addr_q <= cnt_q[YAW-1:0] + 1'b1;
              state_q  <= SEND_RD;
            end
          end
        end

        default: begin
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase

      // Words arriving while the engine or transmitter owns the flow are
      // thrown away; remember that it happened until the next reset.
      if (rx_valid && (state_q == START || state_q == WAIT_DONE ||
                       state_q == SEND_RD || state_q == SEND_TX)) begin
        rx_drop_q <= 1'b1;
      end
    end
  end

  assign k_we      = k_we_q;
  assign k_addr    = k_addr_q;
  assign k_wdata   = k_wdata_q;
  assign x_we      = x_we_q;
  assign x_addr    = x_addr_q;
  assign x_wdata   = x_wdata_q;
  assign mvm_start = mvm_start_q;
  assign y_addr    = y_addr_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign rx_drop   = rx_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_mvm_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mvm_uart_ctrl
// Description : Scoreboard bench for mvm_uart_ctrl with R=2, C=2. Stimulus
//               pushes expected memory writes and transmitted words; a
//               negedge monitor pops and compares them as the DUT emits them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mvm_uart_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        k_we;
  logic [1:0]  k_addr;
  logic [7:0]  k_wdata;
  logic        x_we;
  logic [0:0]  x_addr;
  logic [7:0]  x_wdata;
  logic        mvm_start;
  logic        mvm_done;
  logic [0:0]  y_addr;
  logic [31:0] y_rdata;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic        busy;
  logic        rx_drop;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int tx_cnt = 0;

  logic [1:0]  exp_k_addr[$];
  logic [7:0]  exp_k_data[$];
  logic [0:0]  exp_x_addr[$];
  logic [7:0]  exp_x_data[$];
  logic [31:0] exp_tx[$];

  logic [31:0] ymem[2];

  mvm_uart_ctrl #(.R(2), .C(2), .W_IN(8), .W_Y(32)) dut (
    .clk(clk), .rstn(rstn),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .k_we(k_we), .k_addr(k_addr), .k_wdata(k_wdata),
    .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
    .mvm_start(mvm_start), .mvm_done(mvm_done),
    .y_addr(y_addr), .y_rdata(y_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .rx_drop(rx_drop)
  );

  always #5 clk = ~clk;

  // Result memory with one cycle of read latency.
  always @(posedge clk) y_rdata <= ymem[y_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every strobe the DUT emits.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (k_we) begin
        checks++;
        if (exp_k_addr.size() == 0) begin
          errors++;
          $display("FAIL k_write_unexpected: got addr %0d data %0h expected none", k_addr, k_wdata);
        end else begin
          logic [1:0] ea;
          logic [7:0] ed;
          ea = exp_k_addr.pop_front();
          ed = exp_k_data.pop_front();
          if (k_addr !== ea || k_wdata !== ed) begin
            errors++;
            $display("FAIL k_write: got addr %0d data %0h expected addr %0d data %0h", k_addr, k_wdata, ea, ed);
          end
        end
      end
      if (x_we) begin
        checks++;
        if (exp_x_addr.size() == 0) begin
          errors++;
          $display("FAIL x_write_unexpected: got addr %0d data %0h expected none", x_addr, x_wdata);
        end else begin
          logic [0:0] ea;
          logic [7:0] ed;
          ea = exp_x_addr.pop_front();
          ed = exp_x_data.pop_front();
          if (x_addr !== ea || x_wdata !== ed) begin
            errors++;
            $display("FAIL x_write: got addr %0d data %0h expected addr %0d data %0h", x_addr, x_wdata, ea, ed);
          end
        end
      end
      if (mvm_start) start_cnt++;
      if (tx_valid && tx_ready) begin
        tx_cnt++;
        checks++;
        if (exp_tx.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: got %0h expected none", tx_data);
        end else begin
          logic [31:0] et;
          et = exp_tx.pop_front();
          if (tx_data !== et) begin
            errors++;
            $display("FAIL tx_data: got %0h expected %0h", tx_data, et);
          end
        end
      end
    end
  end

  // Inputs change only at posedge+1; each task returns at that same phase.
  task automatic send_word(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic push_k(input logic [1:0] a, input logic [7:0] d);
    exp_k_addr.push_back(a);
    exp_k_data.push_back(d);
  endtask

  task automatic push_x(input logic [0:0] a, input logic [7:0] d);
    exp_x_addr.push_back(a);
    exp_x_data.push_back(d);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_done();
    mvm_done = 1'b1;
    @(posedge clk); #1;
    mvm_done = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (busy && n < max) begin @(posedge clk); #1; n++; end
    check(name, {63'd0, busy}, 64'd0);
  endtask

  function automatic logic [63:0] all_outputs();
    return {6'd0, k_we, k_addr, k_wdata, x_we, x_addr, x_wdata, mvm_start,
            y_addr, tx_valid, tx_data, busy, rx_drop};
  endfunction

  initial begin
    rstn = 1'b0; rx_valid = 1'b0; rx_data = '0;
    mvm_done = 1'b0; tx_ready = 1'b0;
    ymem[0] = '0; ymem[1] = '0;

    // Reset state
    cycles(3);
    check("reset_outputs", all_outputs(), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    cycles(1);
    check("idle_busy", {63'd0, busy}, 64'd0);

    // Full transfer; a stray mvm_done during LOAD_X must be ignored.
    push_k(2'd0, 8'd1); push_k(2'd1, 8'd2); push_k(2'd2, 8'd3); push_k(2'd3, 8'd4);
    push_x(1'd0, 8'd5); push_x(1'd1, 8'd6);
    send_word(8'd1); send_word(8'd2); send_word(8'd3); send_word(8'd4);
    send_word(8'd5);
    pulse_done();
    cycles(2);
    check("load_x_no_tx", {63'd0, tx_valid}, 64'd0);
    check("load_x_no_start", start_cnt, 0);
    check("load_x_busy", {63'd0, busy}, 64'd1);
    send_word(8'd6);
    cycles(3);
    check("start_pulse_count", start_cnt, 1);
    check("loads_consumed", exp_k_addr.size() + exp_x_addr.size(), 0);
    ymem[0] = 32'h11; ymem[1] = 32'h27;
    exp_tx.push_back(32'h11); exp_tx.push_back(32'h27);
    tx_ready = 1'b1;
    pulse_done();
    wait_idle("run1_idle", 50);
    check("run1_tx_count", tx_cnt, 2);
    check("run1_rx_drop", {63'd0, rx_drop}, 64'd0);
    tx_ready = 1'b0;

    // Second transfer: dropped word in WAIT_DONE, then a stalled transmitter.
    push_k(2'd0, 8'h41); push_k(2'd1, 8'h42); push_k(2'd2, 8'h43); push_k(2'd3, 8'h44);
    push_x(1'd0, 8'h45); push_x(1'd1, 8'h46);
    send_word(8'h41); send_word(8'h42); send_word(8'h43);
    send_word(8'h44); send_word(8'h45); send_word(8'h46);
    cycles(3);
    send_word(8'h77);
    cycles(2);
    check("drop_flag_set", {63'd0, rx_drop}, 64'd1);
    check("run2_start_count", start_cnt, 2);
    ymem[0] = 32'hA5A5_0001; ymem[1] = 32'h0000_0033;
    exp_tx.push_back(32'hA5A5_0001); exp_tx.push_back(32'h0000_0033);
    pulse_done();
    begin
      int n = 0;
      while (!tx_valid && n < 20) begin @(posedge clk); #1; n++; end
      check("stall_tx_valid_seen", {63'd0, tx_valid}, 64'd1);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_hold", {31'd0, tx_valid, tx_data}, {31'd0, 1'b1, 32'hA5A5_0001});
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    cycles(5);
    check("stall_one_handshake", tx_cnt, 3);
    check("second_word_held", {31'd0, tx_valid, tx_data}, {31'd0, 1'b1, 32'h0000_0033});
    tx_ready = 1'b1;
    wait_idle("run2_idle", 50);
    check("run2_tx_count", tx_cnt, 4);
    check("drop_flag_sticky", {63'd0, rx_drop}, 64'd1);
    tx_ready = 1'b0;

    // Reset after the third K word, then reload from element 0.
    push_k(2'd0, 8'h21); push_k(2'd1, 8'h22); push_k(2'd2, 8'h23);
    send_word(8'h21); send_word(8'h22); send_word(8'h23);
    cycles(1);
    rstn = 1'b0;
    #2;
    check("midload_reset_outputs", all_outputs(), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    cycles(1);
    push_k(2'd0, 8'h31); push_k(2'd1, 8'h32); push_k(2'd2, 8'h33); push_k(2'd3, 8'h34);
    send_word(8'h31); send_word(8'h32); send_word(8'h33); send_word(8'h34);
    cycles(2);
    check("reload_consumed", exp_k_addr.size(), 0);
    check("reload_busy", {63'd0, busy}, 64'd1);

    // Abandon the transfer in LOAD_X; nothing may follow the reset.
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    cycles(5);
    check("abandon_quiet", all_outputs(), 64'd0);
    check("final_start_count", start_cnt, 2);
    check("queues_empty", exp_k_addr.size() + exp_x_addr.size() + exp_tx.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
